// File: rtl/key_repeat_if.sv
// Key-level / typematic-pulse bundle between the debounce stage and the
// editor control logic: timebase strobe and key level in, pulses out.
interface key_repeat_if;
    logic tick;
    logic in;
    logic out;
    logic repeating;

    modport master (
        output tick,
        output in,
        input  out,
        input  repeating
    );

    modport slave (
        input  tick,
        input  in,
        output out,
        output repeating
    );
endinterface

// File: rtl/key_repeat.sv
// Typematic pulse generator: one pulse on press, then after DELAY_TICKS ticks
// a train of pulses every RATE_TICKS ticks while the key stays held.
module key_repeat #(
    parameter int DELAY_TICKS = 200,
    parameter int RATE_TICKS  = 40,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    key_repeat_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             out_r;
    logic             out_nxt_s;
    logic             rep_r;

    // State register plus registered outputs; reset cuts any pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ARM;
            cnt_r   <= CNT_ZERO;
            out_r   <= 1'b0;
            rep_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= out_nxt_s;
            rep_r   <= (state_nxt_s == ST_REPEAT);
        end
    end

    // Next-state: release always beats a tick, ARM waits for the key to go up.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARM: begin
                if (!bus.in) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_ARM;
            end
            ST_IDLE: begin
                if (bus.in) state_nxt_s = ST_DELAY;
                else        state_nxt_s = ST_IDLE;
            end
            ST_DELAY: begin
                if (!bus.in)                              state_nxt_s = ST_IDLE;
                else if (bus.tick && cnt_r == DELAY_LAST) state_nxt_s = ST_REPEAT;
                else                                      state_nxt_s = ST_DELAY;
            end
            ST_REPEAT: begin
                if (!bus.in) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_REPEAT;
            end
            default: state_nxt_s = ST_ARM;
        endcase
    end

    // Pulse and tick-counter update; the counter clears at each terminal tick.
    always_comb begin
        out_nxt_s = 1'b0;
        cnt_nxt_s = cnt_r;
        case (state_r)
            ST_ARM: begin
                cnt_nxt_s = CNT_ZERO;
            end
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (bus.in) out_nxt_s = 1'b1;
                else        out_nxt_s = 1'b0;
            end
            ST_DELAY: begin
                if (!bus.in) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (bus.tick) begin
                    if (cnt_r == DELAY_LAST) begin
                        out_nxt_s = 1'b1;
                        cnt_nxt_s = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_REPEAT: begin
                if (!bus.in) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (bus.tick) begin
                    if (cnt_r == RATE_LAST) begin
                        out_nxt_s = 1'b1;
                        cnt_nxt_s = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                out_nxt_s = 1'b0;
                cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    assign bus.out       = out_r;
    assign bus.repeating = rep_r;

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: two instances (DELAY=3/RATE=2 and DELAY=1/RATE=1)
// checked every cycle against a tick-counting model plus literal pulse maps.
module tb_key_repeat;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;
    int   cyc;
    logic [63:0] pulse_a, rep_a, pulse_b, rep_b;

    bit   arm_a, held_a, arm_b, held_b;
    int   n_a, n_b;
    logic m_out_a, m_rep_a, m_out_b, m_rep_b;

    key_repeat_if a_if ();
    key_repeat_if b_if ();

    key_repeat #(.DELAY_TICKS(3), .RATE_TICKS(2), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    key_repeat #(.DELAY_TICKS(1), .RATE_TICKS(1), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0h want=%0h", name, $time, got, exp);
        end
    endtask

    // Model: count ticks since the press; pulse at the DELAY-th tick and at
    // every RATE-th tick after that, as long as the key stays held.
    task automatic model_step(input int d, input int r, input logic rst_v,
                              input logic tick_v, input logic in_v,
                              inout bit armed, inout bit held, inout int n,
                              output logic o, output logic rep);
        o = 1'b0;
        if (rst_v) begin
            armed = 1'b0; held = 1'b0; n = 0;
        end else if (!armed) begin
            if (!in_v) armed = 1'b1;
        end else if (!held) begin
            if (in_v) begin
                held = 1'b1; n = 0; o = 1'b1;
            end
        end else if (!in_v) begin
            held = 1'b0;
        end else if (tick_v) begin
            n++;
            if (n == d || (n > d && ((n - d) % r) == 0)) o = 1'b1;
        end
        rep = armed && held && (n >= d);
    endtask

    always @(posedge clk) begin
        model_step(3, 2, rst, a_if.tick, a_if.in, arm_a, held_a, n_a, m_out_a, m_rep_a);
        model_step(1, 1, rst, b_if.tick, b_if.in, arm_b, held_b, n_b, m_out_b, m_rep_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.out",       {63'd0, a_if.out},       {63'd0, m_out_a});
            check("a.repeating", {63'd0, a_if.repeating}, {63'd0, m_rep_a});
            check("b.out",       {63'd0, b_if.out},       {63'd0, m_out_b});
            check("b.repeating", {63'd0, b_if.repeating}, {63'd0, m_rep_b});
        end
    end

    // One cycle: inputs applied, edge taken, outputs recorded at index cyc.
    task automatic step(input logic ta, input logic ia, input logic ib, input logic r);
        a_if.tick = ta;
        a_if.in   = ia;
        b_if.tick = 1'b1;
        b_if.in   = ib;
        rst       = r;
        @(posedge clk);
        #1;
        if (cyc < 64) begin
            pulse_a[cyc] = a_if.out;
            rep_a[cyc]   = a_if.repeating;
            pulse_b[cyc] = b_if.out;
            rep_b[cyc]   = b_if.repeating;
        end
        cyc++;
    endtask

    task automatic clear_log();
        cyc = 0;
        pulse_a = 64'd0; rep_a = 64'd0; pulse_b = 64'd0; rep_b = 64'd0;
    endtask

    task automatic reset_seq();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        clear_log();
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        arm_a = 1'b0; held_a = 1'b0; n_a = 0;
        arm_b = 1'b0; held_b = 1'b0; n_b = 0;
        clear_log();

        // Reset with the key held, release at 10, press at 12.
        for (int c = 0; c < 16; c++)
            step((c % 4) == 0, !(c == 10 || c == 11), 1'b0, c < 2);
        check("reset.out",       {63'd0, pulse_a[0]}, 64'd0);
        check("reset.repeating", {63'd0, rep_a[0]},   64'd0);
        check("reset.b.out",     {63'd0, pulse_b[1]}, 64'd0);
        chk_en = 1'b1;
        check("held_reset.pulses", pulse_a, 64'h0000_0000_0000_1000);

        // Press at 1, hold through 40.
        reset_seq();
        for (int c = 0; c < 44; c++)
            step((c % 4) == 0, c >= 1 && c <= 40, 1'b0, 1'b0);
        check("hold.pulses",   pulse_a, 64'h0000_0010_1010_1002);
        check("hold.rep@11",   {63'd0, rep_a[11]}, 64'd0);
        check("hold.rep@12",   {63'd0, rep_a[12]}, 64'd1);
        check("hold.rep@41",   {63'd0, rep_a[41]}, 64'd0);

        // Early release at 11, before the third tick.
        reset_seq();
        for (int c = 0; c < 16; c++)
            step((c % 4) == 0, c >= 1 && c <= 10, 1'b0, 1'b0);
        check("early.pulses", pulse_a, 64'h2);
        check("early.rep",    rep_a,   64'd0);

        // Release coincident with the terminal tick at 12.
        reset_seq();
        for (int c = 0; c < 16; c++)
            step((c % 4) == 0, c >= 1 && c <= 11, 1'b0, 1'b0);
        check("tie.pulses", pulse_a, 64'h2);
        check("tie.rep",    rep_a,   64'd0);

        // Reset at 20 during REPEAT with key held; release 26, re-press 28.
        reset_seq();
        for (int c = 0; c < 34; c++)
            step((c % 4) == 0, (c >= 1 && c <= 25) || c >= 28, 1'b0, c == 20);
        check("rst_mid.pulses", pulse_a, 64'h0000_0000_1000_1002);
        check("rst_mid.rep@19", {63'd0, rep_a[19]}, 64'd1);
        check("rst_mid.rep@20", {63'd0, rep_a[20]}, 64'd0);

        // DELAY=1, RATE=1, tick stuck high, key held for 5 cycles.
        reset_seq();
        for (int c = 0; c < 9; c++)
            step(1'b0, 1'b0, c >= 1 && c <= 5, 1'b0);
        check("fast.pulses", pulse_b, 64'h3E);
        check("fast.rep",    rep_b,   64'h3C);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
